fir_ch_scheduler: RTL and testbench
===================================

FIR_CH_SCHEDULER -- requirements
Module: fir_ch_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of requesting channels (2..8).
REQ-002 Parameter DATA_W, default 16, sample width.
REQ-003 Parameter OUT_W, default 38, FIR result width.
REQ-004 Parameter TIMEOUT, default 72, maximum cycles to wait for the FIR engine result.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  NUM_CH  per-channel sample request.
REQ-008 req_data  input  NUM_CH*DATA_W  per-channel samples; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 req_ready  output  NUM_CH  one-hot accept strobe for the granted channel.
REQ-010 fir_in_valid  output  1  one-cycle start pulse to the FIR engine.
REQ-011 fir_in_data  output  DATA_W  registered sample sent to the engine.
REQ-012 fir_out_valid  input  1  engine result strobe.
REQ-013 fir_out_data  input  OUT_W  engine result.
REQ-014 res_valid  output  1  result available.
REQ-015 res_data  output  OUT_W  result value.
REQ-016 res_ch  output  $clog2(NUM_CH)  channel index of the result.
REQ-017 res_err  output  1  result is a timeout error; res_data is 0.
REQ-018 res_ready  input  1  result consumer accept.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 The block SHALL implement FSM states IDLE, ISSUE, WAIT and HOLD, with all outputs driven from registers or decoded from the state only.
REQ-021 IDLE: when any req_valid bit is high, the block SHALL grant exactly one channel, pulse req_ready for that channel in the same cycle, latch its sample and index, and move to ISSUE; otherwise it SHALL remain in IDLE.
REQ-022 Grant selection SHALL be round-robin: search starts at (last_grant+1) mod NUM_CH; after reset, last_grant = NUM_CH-1 so channel 0 has first priority.
REQ-023 last_grant SHALL update only on a grant.
REQ-024 ISSUE: fir_in_valid=1 for exactly one cycle with fir_in_data = latched sample, then WAIT.
REQ-025 WAIT: a cycle counter SHALL clear on entry and increment each cycle.
REQ-026 WAIT: on fir_out_valid, the block SHALL capture fir_out_data into res_data, set res_err=0 and move to HOLD.
REQ-027 WAIT: when the counter reaches TIMEOUT without fir_out_valid, the block SHALL set res_err=1 and res_data=0 and move to HOLD.
REQ-028 If fir_out_valid arrives in the same cycle the counter reaches TIMEOUT, the result SHALL win and res_err SHALL be 0.
REQ-029 HOLD: res_valid=1 with res_data, res_ch and res_err stable until res_ready is high; the handshake cycle SHALL return the block to IDLE.
REQ-030 fir_out_valid outside WAIT SHALL be ignored.
REQ-031 req_valid and req_data SHALL be ignored outside IDLE, and req_ready SHALL be all-zero outside the IDLE grant cycle.
REQ-032 Latency: grant at cycle T gives fir_in_valid at T+1; fir_out_valid at cycle R gives res_valid at R+1.
REQ-033 Minimum grant-to-grant spacing SHALL be 4 cycles: the earliest new grant is the cycle after the res_ready handshake.

Reset
REQ-034 Asserting rst low SHALL immediately force IDLE, clear last_grant to NUM_CH-1, and clear the counter, latched sample, res_data, res_ch and res_err.
REQ-035 During reset, req_ready, fir_in_valid, res_valid and busy SHALL be 0.
REQ-036 Reset in any state, including mid-WAIT, SHALL discard the in-flight request without producing a result.
REQ-037 The first grant SHALL occur no earlier than the first rising edge after rst deasserts.

Verification
REQ-038 Single request: req_valid=4'b0100, data 0x1234, engine returns 0x55 after 64 cycles, res_ready=1 -> req_ready=4'b0100, fir_in_data=0x1234, res_valid with res_data=0x55, res_ch=2, res_err=0.
REQ-039 All-channel contention: req_valid=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-040 Timeout: fir_out_valid never asserted -> res_valid exactly TIMEOUT+1 cycles after fir_in_valid, res_err=1, res_data=0.
REQ-041 Backpressure: res_ready=0 for 10 cycles -> res_valid, res_data and res_ch held, req_ready stays 0 throughout, and a stray fir_out_valid is ignored.
REQ-042 Reset mid-WAIT: rst low at cycle 20 of WAIT -> busy=0 immediately, no res_valid, and the next grant is channel 0.
REQ-043 Tie at timeout: fir_out_valid on the cycle the counter reaches TIMEOUT -> res_err=0 and res_data equals the engine value.

Source files
------------

// File: rtl/fir_ch_scheduler.sv
// rtl/fir_ch_scheduler.sv - round-robin multi-channel request scheduler for a shared FIR engine
module fir_ch_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 16,
    parameter int OUT_W   = 38,
    parameter int TIMEOUT = 72
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*DATA_W-1:0]   req_data,
    output logic [NUM_CH-1:0]          req_ready,
    output logic                       fir_in_valid,
    output logic [DATA_W-1:0]          fir_in_data,
    input  logic                       fir_out_valid,
    input  logic [OUT_W-1:0]           fir_out_data,
    output logic                       res_valid,
    output logic [OUT_W-1:0]           res_data,
    output logic [$clog2(NUM_CH)-1:0]  res_ch,
    output logic                       res_err,
    input  logic                       res_ready,
    output logic                       busy
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CH_W-1:0]     r_last;
    logic [CH_W-1:0]     r_ch;
    logic [DATA_W-1:0]   r_sample;
    logic [CNT_W-1:0]    r_cnt;
    logic [OUT_W-1:0]    r_res;
    logic                r_err;

    logic                w_any;
    logic [CH_W-1:0]     w_gnt_idx;
    logic [DATA_W-1:0]   w_sample;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout;
    logic                w_grant;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_sample  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            automatic int idx = (int'(r_last) + 1 + i) % NUM_CH;
            if (!w_any && req_valid[idx]) begin
                w_any     = 1'b1;
                w_gnt_idx = CH_W'(idx);
                w_sample  = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign w_grant   = (r_state == S_IDLE) && w_any && rst;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            // An engine result in the timeout cycle takes precedence over the error.
            S_WAIT:  if (fir_out_valid || w_timeout) w_next = S_HOLD;
            S_HOLD:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last   <= CH_W'(NUM_CH - 1);
            r_ch     <= '0;
            r_sample <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last   <= w_gnt_idx;
                r_ch     <= w_gnt_idx;
                r_sample <= w_sample;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= w_cnt_inc;
                if (fir_out_valid) begin
                    r_res <= fir_out_data;
                    r_err <= 1'b0;
                end else if (w_timeout) begin
                    r_res <= '0;
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign req_ready    = w_grant ? (NUM_CH'(1) << w_gnt_idx) : '0;
    assign fir_in_valid = (r_state == S_ISSUE);
    assign fir_in_data  = r_sample;
    assign res_valid    = (r_state == S_HOLD);
    assign res_data     = r_res;
    assign res_ch       = r_ch;
    assign res_err      = r_err;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_ch_scheduler.sv
// tb/tb_fir_ch_scheduler.sv - directed self-checking bench for fir_ch_scheduler
module tb_fir_ch_scheduler;
    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 16;
    localparam int OUT_W   = 38;
    localparam int TIMEOUT = 72;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_CH-1:0]         req_valid;
    logic [NUM_CH*DATA_W-1:0]  req_data;
    logic [NUM_CH-1:0]         req_ready;
    logic                      fir_in_valid;
    logic [DATA_W-1:0]         fir_in_data;
    logic                      fir_out_valid;
    logic [OUT_W-1:0]          fir_out_data;
    logic                      res_valid;
    logic [OUT_W-1:0]          res_data;
    logic [1:0]                res_ch;
    logic                      res_err;
    logic                      res_ready;
    logic                      busy;

    int n_cmp  = 0;
    int n_fail = 0;

    fir_ch_scheduler #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fir_in_valid (fir_in_valid),
        .fir_in_data  (fir_in_data),
        .fir_out_valid(fir_out_valid),
        .fir_out_data (fir_out_data),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ch       (res_ch),
        .res_err      (res_err),
        .res_ready    (res_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full request-to-handshake transaction; d < 0 means the engine never answers.
    task automatic run_txn(input logic [3:0] rv, input logic [63:0] rd, input logic [3:0] exp_gnt,
                           input logic [15:0] exp_smp, input int d, input logic [37:0] val,
                           input int exp_n, input logic exp_err, input logic [37:0] exp_res,
                           input logic [1:0] exp_ch, input int hold);
        int  n;
        logic seen;
        @(negedge clk);
        req_valid = rv;
        req_data  = rd;
        res_ready = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("grant", req_ready, exp_gnt);
        @(negedge clk);
        #1;
        chk("issue_valid", fir_in_valid, 1);
        chk("issue_data", fir_in_data, exp_smp);
        chk("issue_ready0", req_ready, 0);
        chk("issue_busy", busy, 1);
        n    = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            fir_out_valid = (n == d);
            fir_out_data  = (n == d) ? val : '0;
            #1;
            if (n == 1) chk("in_valid_pulse", fir_in_valid, 0);
            seen = res_valid;
        end
        fir_out_valid = 1'b0;
        chk("latency", n, exp_n);
        chk("res_data", res_data, exp_res);
        chk("res_ch", res_ch, exp_ch);
        chk("res_err", res_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            fir_out_valid = (h == 4);
            fir_out_data  = 38'h3FFF;
            #1;
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, exp_res);
            chk("bp_ch", res_ch, exp_ch);
            chk("bp_ready0", req_ready, 0);
        end
        fir_out_valid = 1'b0;
        fir_out_data  = '0;
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        chk("hs_valid", res_valid, 1);
        @(negedge clk);
        res_ready = 1'b0;
        req_valid = '0;
        #1;
        chk("post_hs_valid", res_valid, 0);
        chk("post_hs_busy", busy, 0);
    endtask

    initial begin
        logic [63:0] all_d;
        logic [3:0]  gnt;
        int          d;
        all_d         = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        rst           = 1'b0;
        req_valid     = 4'b1111;
        req_data      = all_d;
        fir_out_valid = 1'b0;
        fir_out_data  = '0;
        res_ready     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fir_in_valid", fir_in_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_res_data", res_data, 0);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;

        for (int i = 0; i < 8; i++) begin
            gnt = 4'b0001 << (i % 4);
            d   = (i % 3) + 1;
            run_txn(4'b1111, all_d, gnt, 16'(16'h1000 + i % 4), d, 38'(100 + i),
                    d + 1, 1'b0, 38'(100 + i), 2'(i % 4), 0);
        end

        run_txn(4'b0100, {16'h0000, 16'h1234, 16'h0000, 16'h0000}, 4'b0100, 16'h1234,
                64, 38'h55, 65, 1'b0, 38'h55, 2'd2, 10);

        run_txn(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hBEEF}, 4'b0001, 16'hBEEF,
                -1, 38'h0, TIMEOUT + 1, 1'b1, 38'h0, 2'd0, 0);

        run_txn(4'b0010, {16'h0000, 16'h0000, 16'h0F0F, 16'h0000}, 4'b0010, 16'h0F0F,
                TIMEOUT, 38'h2ABCDEF01, TIMEOUT + 1, 1'b0, 38'h2ABCDEF01, 2'd1, 0);

        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = {16'h0000, 16'h7777, 16'h0000, 16'h0000};
        #1;
        chk("mw_grant", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("mw_issue_data", fir_in_data, 16'h7777);
        repeat (20) @(negedge clk);
        #1;
        chk("mw_busy_wait", busy, 1);
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_data  = all_d;
        #1;
        chk("mw_busy_rst", busy, 0);
        chk("mw_res_valid_rst", res_valid, 0);
        chk("mw_req_ready_rst", req_ready, 0);
        chk("mw_fir_in_rst", fir_in_valid, 0);
        @(negedge clk);
        #1;
        chk("mw_req_ready_hold", req_ready, 0);
        rst       = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("mw_no_result", res_valid, 0);
        end
        run_txn(4'b1111, all_d, 4'b0001, 16'h1000, 3, 38'h77, 4, 1'b0, 38'h77, 2'd0, 0);

        @(negedge clk);
        #1;
        chk("end_busy", busy, 0);
        chk("end_res_valid", res_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
